// File: rtl/sync_fifo_queue.sv
// sync_fifo_queue: single-clock FIFO with an occupancy count, programmable
// almost-full/almost-empty flags and pass-through push-while-full.
// The head entry falls through to data_out without a read.
// Optional build macro SYNC_FIFO_ERR_FLAGS_EN adds sticky overflow and
// underflow flags, which err_clr clears. Without the macro both flags read 0
// and err_clr has no effect. The port list is the same in both builds.
module sync_fifo_queue #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       we,
    input  logic                       re,
    output logic [WIDTH-1:0]           data_out,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] LVL_AF   = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] LVL_AE   = (AW+1)'(AE_THRESH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [AW:0]      r_level;

    logic w_full;
    logic w_empty;
    logic w_rd_ok;
    logic w_wr_ok;

    // Status flags are decoded from the registered level alone.
    // A write into a full FIFO is accepted only together with a read, which frees the slot at wp == rp.
    always_comb begin
        w_full  = (r_level == LVL_FULL);
        w_empty = (r_level == '0);
        w_rd_ok = re & ~w_empty;
        w_wr_ok = we & (~w_full | re);
    end

    // Storage: store on an accepted write; reset clears every entry so data_out reads 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[AW'(i)] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[r_wp] <= data_in;
        end
    end

    // Pointers and occupancy: both pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_rd_ok) begin
                r_rp <= r_rp + AW'(1);
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky error flags: a new offending request in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (we & ~w_wr_ok) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (re & w_empty) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    logic w_unused_err_clr;

    assign w_unused_err_clr = err_clr;
    assign overflow         = 1'b0;
    assign underflow        = 1'b0;
`endif

    assign data_out     = r_mem[r_rp];
    assign full         = w_full;
    assign empty        = w_empty;
    assign level        = r_level;
    assign almost_full  = (r_level >= LVL_AF);
    assign almost_empty = (r_level <= LVL_AE);

endmodule
